// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus the ALU drive/return bus for alu_op_sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_eq;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic             alu_eq;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_eq,
    output req_ready, rsp_valid, rsp_result, rsp_eq, alu_a, alu_b, alu_op, alu_cin
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_eq,
    input  req_ready, rsp_valid, rsp_result, rsp_eq, alu_a, alu_b, alu_op, alu_cin
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-pass controller that builds SUB/OR/AND/SLT out of a shared ADD/NOR ALU,
// running 1-3 passes through internal temporaries per accepted request.
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_NOR = 3'd1, OP_SUB = 3'd2, OP_OR = 3'd3,
    OP_AND = 3'd4, OP_SLT = 3'd5, OP_BAD6 = 3'd6, OP_BAD7 = 3'd7
  } op_e;

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_result;
  logic             r_eq;

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic             w_alu_op;
  logic             w_alu_cin;
  logic             w_accept;
  logic             w_slt_bit;
  logic             w_short_op;

  assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
  assign w_short_op = (r_op == OP_ADD) || (r_op == OP_NOR) || (r_op == OP_BAD6) || (r_op == OP_BAD7);
  // Signs differ: A<B exactly when A is negative; otherwise the difference sign cannot overflow.
  assign w_slt_bit  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? r_a[WIDTH-1] : bus.alu_out[WIDTH-1];

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    w_next    = r_state;
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_op  = 1'b0;
    w_alu_cin = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_P1;
      S_P1: begin
        w_next = w_short_op ? S_DONE : S_P2;
        case (r_op)
          OP_ADD:         begin w_alu_a = r_a; w_alu_b = r_b; end
          OP_NOR, OP_OR:  begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = 1'b1; end
          OP_SUB, OP_SLT: begin w_alu_a = r_b; w_alu_b = r_b; w_alu_op = 1'b1; end
          OP_AND:         begin w_alu_a = r_a; w_alu_b = r_a; w_alu_op = 1'b1; end
          default: ;
        endcase
      end
      S_P2: begin
        w_next = (r_op == OP_AND) ? S_P3 : S_DONE;
        case (r_op)
          OP_SUB, OP_SLT: begin w_alu_a = r_a; w_alu_b = r_t; w_alu_cin = 1'b1; end
          OP_OR:          begin w_alu_a = r_t; w_alu_b = r_t; w_alu_op = 1'b1; end
          OP_AND:         begin w_alu_a = r_b; w_alu_b = r_b; w_alu_op = 1'b1; end
          default: ;
        endcase
      end
      S_P3: begin
        w_next   = S_DONE;
        w_alu_a  = r_t;
        w_alu_b  = r_u;
        w_alu_op = 1'b1;
      end
      S_DONE: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: operand and temporary registers are reset too, so the ALU drive and the
  // response are deterministic straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_t      <= '0;
      r_u      <= '0;
      r_result <= '0;
      r_eq     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= op_e'(bus.req_op);
          r_a  <= bus.req_a;
          r_b  <= bus.req_b;
        end
        S_P1: begin
          case (r_op)
            OP_ADD, OP_NOR: begin r_result <= bus.alu_out; r_eq <= bus.alu_eq; end
            OP_SUB, OP_SLT, OP_AND: r_t <= bus.alu_out;
            OP_OR:          begin r_t <= bus.alu_out; r_eq <= bus.alu_eq; end
            default:        begin r_result <= '0; r_eq <= 1'b0; end
          endcase
        end
        S_P2: begin
          case (r_op)
            OP_SUB: begin r_result <= bus.alu_out; r_eq <= (bus.alu_out == '0); end
            OP_SLT: begin
              r_result <= {{(WIDTH-1){1'b0}}, w_slt_bit};
              r_eq     <= (bus.alu_out == '0);
            end
            OP_OR:   r_result <= bus.alu_out;
            OP_AND:  r_u <= bus.alu_out;
            default: ;
          endcase
        end
        S_P3: begin
          r_result <= bus.alu_out;
          r_eq     <= bus.alu_eq;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = (r_state == S_DONE);
  assign bus.rsp_result = r_result;
  assign bus.rsp_eq     = r_eq;
  assign bus.alu_a      = w_alu_a;
  assign bus.alu_b      = w_alu_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.alu_cin    = w_alu_cin;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: alu_op_sequencer paired with an ADD/NOR ALU model, directed
// cases followed by random ops compared against an arithmetic reference model.
module tb_alu_op_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] res;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always_comb begin
    bus.alu_out = bus.alu_op ? ~(bus.alu_a | bus.alu_b)
                             : bus.alu_a + bus.alu_b + {{(W-1){1'b0}}, bus.alu_cin};
    bus.alu_eq  = (bus.alu_a == bus.alu_b);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: result, equality flag and cycles from accept to rsp_valid.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e, output int n);
    e = (op <= 3'd5) ? (a == b) : 1'b0;
    case (op)
      3'd0:    begin r = a + b;    n = 1; end
      3'd1:    begin r = ~(a | b); n = 1; end
      3'd2:    begin r = a - b;    n = 2; end
      3'd3:    begin r = a | b;    n = 2; end
      3'd4:    begin r = a & b;    n = 3; end
      3'd5:    begin r = ($signed(a) < $signed(b)) ? W'(1) : W'(0); n = 2; end
      default: begin r = '0;       n = 1; end
    endcase
  endfunction

  // Called #1 after a rising edge with the sequencer idle; returns the same way.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] got);
    logic [W-1:0] exp_r;
    logic         exp_e;
    int           exp_n;
    int           lat;
    logic         all_nor, any_cin, rdy_seen;
    model(op, a, b, exp_r, exp_e, exp_n);
    bus.rsp_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_op    = 3'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    lat = 0; all_nor = 1'b1; any_cin = 1'b0; rdy_seen = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      all_nor  &= bus.alu_op;
      any_cin  |= bus.alu_cin;
      rdy_seen |= bus.req_ready;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), W'(lat), W'(exp_n));
    check($sformatf("result op%0d", op), bus.rsp_result, exp_r);
    check($sformatf("eq op%0d", op), W'(bus.rsp_eq), W'(exp_e));
    check("ready_low_while_busy", W'(rdy_seen), W'(0));
    if (op == 3'd4) begin
      check("and_alu_op_nor", W'(all_nor), W'(1));
      check("and_alu_cin_zero", W'(any_cin), W'(0));
    end
    got = bus.rsp_result;
    if (hold > 0) bus.req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", W'(bus.rsp_valid), W'(1));
      check("hold_result", bus.rsp_result, exp_r);
      check("hold_req_ready", W'(bus.req_ready), W'(0));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_valid", W'(bus.rsp_valid), W'(0));
    check("post_req_ready", W'(bus.req_ready), W'(1));
    check("post_result_kept", bus.rsp_result, exp_r);
    check("post_alu_a_zero", bus.alu_a, W'(0));
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #2;
    check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
    check("rst_rsp_result", bus.rsp_result, W'(0));
    check("rst_rsp_eq", W'(bus.rsp_eq), W'(0));
    check("rst_req_ready", W'(bus.req_ready), W'(1));
    check("rst_alu_b", bus.alu_b, W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'd5, 32'd7, 0, res);
    check("add_5_7", res, 32'd12);
    run_op(3'd2, 32'd3, 32'd5, 0, res);
    check("sub_3_5", res, 32'hFFFF_FFFE);
    run_op(3'd2, 32'd9, 32'd9, 0, res);
    check("sub_9_9", res, 32'd0);
    run_op(3'd4, 32'hF0F0_FFFF, 32'h0FF0_00FF, 0, res);
    check("and_const", res, 32'h00F0_00FF);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0, res);
    check("slt_m1_1", res, 32'd1);
    run_op(3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 0, res);
    check("slt_overflow", res, 32'd0);
    run_op(3'd3, 32'h0000_00A0, 32'h0000_000A, 0, res);
    check("or_const", res, 32'h0000_00AA);
    run_op(3'd1, 32'h1234_5678, 32'h1234_5678, 0, res);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5, res);
    run_op(3'd7, 32'd4, 32'd4, 0, res);
    check("illegal_zero", res, 32'd0);

    // Reset while AND is in its second pass.
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_a     = 32'hDEAD_BEEF;
    bus.req_b     = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("p2_alu_op", W'(bus.alu_op), W'(1));
    check("p2_alu_a", bus.alu_a, 32'h1234_5678);
    reset = 1'b1;
    #1;
    check("abort_alu_a", bus.alu_a, W'(0));
    check("abort_alu_b", bus.alu_b, W'(0));
    check("abort_alu_op", W'(bus.alu_op), W'(0));
    check("abort_req_ready", W'(bus.req_ready), W'(1));
    check("abort_rsp_valid", W'(bus.rsp_valid), W'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", W'(bus.rsp_valid), W'(0));
    end
    run_op(3'd0, 32'd1, 32'd1, 0, res);
    check("add_after_reset", res, 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 2), res);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
